// File: rtl/mac_reg_slave.sv
// Avalon-MM register responder for the MAC configuration space.
// Inserts WAIT_CYCLES wait states, holds MAC config registers and counts unmapped accesses.
module mac_reg_slave #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] REV         = 32'h0000_0901
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  address,
    input  logic        write,
    input  logic        read,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        tx_ena,
    output logic        rx_ena,
    output logic [7:0]  fifo_thresh,
    output logic [3:0]  pcs_ctrl,
    output logic        sw_reset,
    output logic        cfg_update
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [7:0] ADDR_REV     = 8'h00;
    localparam logic [7:0] ADDR_SCRATCH = 8'h01;
    localparam logic [7:0] ADDR_CMD     = 8'h02;
    localparam logic [7:0] ADDR_UNMAP   = 8'h03;
    localparam logic [7:0] ADDR_FIFO    = 8'h0E;
    localparam logic [7:0] ADDR_PCS     = 8'h94;

    localparam logic [3:0]  WAIT_INIT  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] SW_RST_BIT = 32'h0000_2000;

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [3:0]  cnt;
    logic [7:0]  lat_addr;
    logic [31:0] lat_data;
    logic        lat_wr;

    logic [31:0] scratch;
    logic [31:0] cmd_cfg;
    logic [7:0]  unmapped_cnt;

    logic [7:0]  acc_addr;
    logic [31:0] acc_data;
    logic        acc_wr;
    logic        commit;
    logic        mapped;
    logic        writable;
    logic [31:0] rd_mux;

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: if (write || read) next_state = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
            ST_WAIT: if (cnt == 4'd0) next_state = ST_ACK;
            ST_ACK:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // With zero wait states the commit edge is also the sampling edge, so use live inputs.
    always_comb begin
        acc_addr = (state == ST_IDLE) ? address   : lat_addr;
        acc_data = (state == ST_IDLE) ? writedata : lat_data;
        acc_wr   = (state == ST_IDLE) ? write     : lat_wr;
        commit   = (next_state == ST_ACK) && (state != ST_ACK);
        mapped   = 1'b1;
        writable = 1'b0;
        rd_mux   = 32'h0;
        unique case (acc_addr)
            ADDR_REV:     rd_mux = REV;
            ADDR_SCRATCH: begin rd_mux = scratch;               writable = 1'b1; end
            ADDR_CMD:     begin rd_mux = cmd_cfg;               writable = 1'b1; end
            ADDR_UNMAP:   rd_mux = {24'h0, unmapped_cnt};
            ADDR_FIFO:    begin rd_mux = {24'h0, fifo_thresh};  writable = 1'b1; end
            ADDR_PCS:     begin rd_mux = {28'h0, pcs_ctrl};     writable = 1'b1; end
            default:      mapped = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            lat_addr    <= 8'h0;
            lat_data    <= 32'h0;
            lat_wr      <= 1'b0;
            waitrequest <= 1'b1;
            cfg_update  <= 1'b0;
            sw_reset    <= 1'b0;
        end else begin
            state       <= next_state;
            waitrequest <= (next_state != ST_ACK);
            cfg_update  <= commit && acc_wr && writable;
            sw_reset    <= commit && acc_wr && (acc_addr == ADDR_CMD) && acc_data[13];
            if (state == ST_IDLE && (write || read)) begin
                lat_addr <= address;
                lat_data <= writedata;
                lat_wr   <= write;
                cnt      <= WAIT_INIT;
            end else if (state == ST_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdata     <= 32'h0;
            scratch      <= 32'h0;
            cmd_cfg      <= 32'h0;
            fifo_thresh  <= 8'h10;
            pcs_ctrl     <= 4'h0;
            unmapped_cnt <= 8'h0;
        end else if (commit) begin
            if (!acc_wr) readdata <= rd_mux;
            if (acc_wr) begin
                unique case (acc_addr)
                    ADDR_SCRATCH: scratch     <= acc_data;
                    ADDR_CMD:     cmd_cfg     <= acc_data & ~SW_RST_BIT;
                    ADDR_FIFO:    fifo_thresh <= acc_data[7:0];
                    ADDR_PCS:     pcs_ctrl    <= acc_data[3:0];
                    default:      ;
                endcase
            end
            if (!mapped && unmapped_cnt != 8'hFF) unmapped_cnt <= unmapped_cnt + 8'd1;
        end
    end

    assign tx_ena = cmd_cfg[0];
    assign rx_ena = cmd_cfg[1];

endmodule

// File: tb/tb_mac_reg_slave.sv
// Directed self-checking bench for mac_reg_slave (WAIT_CYCLES=2).
module tb_mac_reg_slave;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  address;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        tx_ena;
    logic        rx_ena;
    logic [7:0]  fifo_thresh;
    logic [3:0]  pcs_ctrl;
    logic        sw_reset;
    logic        cfg_update;

    int checks   = 0;
    int failures = 0;

    mac_reg_slave #(.WAIT_CYCLES(W), .REV(32'h0000_0901)) dut (
        .clk(clk), .reset(reset), .address(address), .write(write), .read(read),
        .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata),
        .tx_ena(tx_ena), .rx_ena(rx_ena), .fifo_thresh(fifo_thresh), .pcs_ctrl(pcs_ctrl),
        .sw_reset(sw_reset), .cfg_update(cfg_update)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One transaction; the request is dropped after the sampling edge, so completion relies on latched values.
    task automatic access(input logic wr, input logic rd, input logic [7:0] addr, input logic [31:0] data,
                          input string tag, output logic [31:0] rdata, output logic cu, output logic sr);
        int lat;
        @(negedge clk);
        write = wr; read = rd; address = addr; writedata = data;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin write = 1'b0; read = 1'b0; end
        end while (waitrequest && lat < 40);
        check({tag, "_latency"}, lat, W + 1);
        rdata = readdata; cu = cfg_update; sr = sw_reset;
        @(posedge clk); #1;
        check({tag, "_wr_back_high"}, {31'h0, waitrequest}, 32'h1);
        check({tag, "_pulses_end"}, {30'h0, cfg_update, sw_reset}, 32'h0);
    endtask

    logic [31:0] rd;
    logic        cu, sr;
    int          n, bad_rd, bad_cu;

    initial begin
        reset = 1'b0; write = 1'b0; read = 1'b0; address = 8'h0; writedata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_waitrequest", {31'h0, waitrequest}, 32'h1);
        check("rst_readdata", readdata, 32'h0);
        check("rst_fifo_thresh", {24'h0, fifo_thresh}, 32'h10);
        check("rst_ctrl", {26'h0, tx_ena, rx_ena, pcs_ctrl}, 32'h0);
        check("rst_pulses", {30'h0, sw_reset, cfg_update}, 32'h0);
        @(negedge clk) reset = 1'b1;

        access(1'b0, 1'b1, 8'h00, 32'h0, "rd_rev", rd, cu, sr);
        check("rev_value", rd, 32'h0000_0901);
        check("rev_fifo_thresh", {24'h0, fifo_thresh}, 32'h10);

        access(1'b1, 1'b0, 8'h00, 32'hFFFF_FFFF, "wr_rev", rd, cu, sr);
        check("wr_rev_no_cfg_update", {31'h0, cu}, 32'h0);
        access(1'b0, 1'b1, 8'h03, 32'h0, "rd_cnt0", rd, cu, sr);
        check("rev_write_not_unmapped", rd, 32'h0);

        access(1'b1, 1'b0, 8'h02, 32'h0100_0093, "wr_cmd", rd, cu, sr);
        check("wr_cmd_cfg_update", {31'h0, cu}, 32'h1);
        check("wr_cmd_no_sw_reset", {31'h0, sr}, 32'h0);
        check("cmd_tx_rx_ena", {30'h0, tx_ena, rx_ena}, 32'h3);
        access(1'b0, 1'b1, 8'h02, 32'h0, "rd_cmd", rd, cu, sr);
        check("cmd_readback", rd, 32'h0100_0093);
        check("rd_no_cfg_update", {31'h0, cu}, 32'h0);

        // Back-to-back writes with write held high: ACKs W+2 cycles apart.
        @(negedge clk);
        write = 1'b1; address = 8'h0E; writedata = 32'h4;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (waitrequest && n < 40);
        check("b2b_first_latency", n, W + 1);
        address = 8'h94; writedata = 32'h7;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (waitrequest && n < 40);
        check("b2b_ack_spacing", n, W + 2);
        check("b2b_cfg_update", {31'h0, cfg_update}, 32'h1);
        write = 1'b0;
        @(posedge clk); #1;
        check("b2b_fifo_thresh", {24'h0, fifo_thresh}, 32'h04);
        check("b2b_pcs_ctrl", {28'h0, pcs_ctrl}, 32'h7);

        access(1'b1, 1'b0, 8'h02, 32'h0000_2003, "wr_swrst", rd, cu, sr);
        check("sw_reset_pulse", {31'h0, sr}, 32'h1);
        access(1'b0, 1'b1, 8'h02, 32'h0, "rd_swrst", rd, cu, sr);
        check("sw_reset_bit_clear", rd, 32'h0000_0003);

        // read+write together must act as a write; readdata keeps the previous read value.
        access(1'b1, 1'b1, 8'h01, 32'h1234_5678, "rw_both", rd, cu, sr);
        check("rw_both_readdata_held", rd, 32'h0000_0003);
        check("rw_both_cfg_update", {31'h0, cu}, 32'h1);
        access(1'b0, 1'b1, 8'h01, 32'h0, "rd_scratch", rd, cu, sr);
        check("scratch_readback", rd, 32'h1234_5678);

        bad_rd = 0; bad_cu = 0;
        for (int i = 0; i < 300; i++) begin
            access(i[0], ~i[0], 8'h55, 32'hFFFF_FFFF, "unmapped", rd, cu, sr);
            if (!i[0] && rd != 32'h0) bad_rd++;
            if (cu) bad_cu++;
        end
        check("unmapped_read_zero", bad_rd, 0);
        check("unmapped_no_cfg_update", bad_cu, 0);
        access(1'b0, 1'b1, 8'h03, 32'h0, "rd_cnt_sat", rd, cu, sr);
        check("unmapped_cnt_saturated", rd, 32'h0000_00FF);

        // Reset during WAIT of a write to SCRATCH: no ACK, nothing committed.
        @(negedge clk);
        write = 1'b1; address = 8'h01; writedata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        write = 1'b0; reset = 1'b0;
        #1;
        check("midrst_waitrequest", {31'h0, waitrequest}, 32'h1);
        n = 0;
        repeat (4) begin @(posedge clk); #1; if (!waitrequest) n++; end
        check("midrst_no_ack", n, 0);
        @(negedge clk) reset = 1'b1;
        access(1'b0, 1'b1, 8'h01, 32'h0, "rd_scratch_rst", rd, cu, sr);
        check("midrst_scratch_zero", rd, 32'h0);
        check("midrst_fifo_thresh", {24'h0, fifo_thresh}, 32'h10);
        check("midrst_ctrl", {26'h0, tx_ena, rx_ena, pcs_ctrl}, 32'h0);
        access(1'b0, 1'b1, 8'h03, 32'h0, "rd_cnt_rst", rd, cu, sr);
        check("midrst_unmapped_cnt", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
